// File: rtl/exec_flag_unit.sv
// Execute stage with flag generation: single-cycle ALU ops plus a 32-step
// shift-add multiplier (MUL/MLA), driving the NZCV status register write port.
module exec_flag_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       exe_cmd,
  input  logic             s_bit,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic [WIDTH-1:0] acc,
  input  logic [3:0]       status_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       status_out,
  output logic             status_wr_en
);

  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_ORR = 4'b0111;
  localparam logic [3:0] OP_EOR = 4'b1000;
  localparam logic [3:0] OP_MVN = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;
  localparam logic [3:0] OP_MLA = 4'b1011;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    FIN
  } state_t;

  state_t           state_q;
  logic [3:0]       cmd_q;
  logic             sBit_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       status_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] prod_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             wrEn_q;

  logic [WIDTH-1:0] aluRes_d;
  logic [3:0]       aluFlags_d;
  logic             defined_d;
  logic [WIDTH:0]   addSum;
  logic [WIDTH:0]   subSum;
  logic             carry_d;
  logic             ovf_d;

  // Subtraction is A + ~B + cin, so the carry out is already NOT borrow.
  always_comb begin
    aluRes_d   = '0;
    aluFlags_d = status_q;
    defined_d  = 1'b1;
    carry_d    = status_q[1];
    ovf_d      = status_q[0];
    addSum     = {1'b0, a_q} + {1'b0, b_q}
               + (WIDTH+1)'((cmd_q == OP_ADC) ? status_q[1] : 1'b0);
    subSum     = {1'b0, a_q} + {1'b0, ~b_q}
               + (WIDTH+1)'((cmd_q == OP_SBC) ? status_q[1] : 1'b1);
    case (cmd_q)
      OP_MOV: aluRes_d = b_q;
      OP_MVN: aluRes_d = ~b_q;
      OP_ADD, OP_ADC: begin
        aluRes_d = addSum[WIDTH-1:0];
        carry_d  = addSum[WIDTH];
        ovf_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                   (addSum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB, OP_SBC: begin
        aluRes_d = subSum[WIDTH-1:0];
        carry_d  = subSum[WIDTH];
        ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                   (subSum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: aluRes_d = a_q & b_q;
      OP_ORR: aluRes_d = a_q | b_q;
      OP_EOR: aluRes_d = a_q ^ b_q;
      OP_MUL, OP_MLA: aluRes_d = prod_q;
      default: defined_d = 1'b0;
    endcase
    if (defined_d) begin
      aluFlags_d = {aluRes_d[WIDTH-1], (aluRes_d == '0), carry_d, ovf_d};
    end
  end

  // Control FSM; all outputs are registered so status_out/status_wr_en stay
  // stable across the negedge where the status register captures them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      sBit_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      status_q <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      wrEn_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrEn_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cmd_q    <= exe_cmd;
            sBit_q   <= s_bit;
            a_q      <= val1;
            b_q      <= val2;
            status_q <= status_in;
            cnt_q    <= '0;
            prod_q   <= (exe_cmd == OP_MLA) ? acc : '0;
            mcand_q  <= val1;
            mplier_q <= val2;
            busy_q   <= 1'b1;
            if (exe_cmd == OP_MUL || exe_cmd == OP_MLA) begin
              state_q <= MULT;
            end else begin
              state_q <= FIN;
            end
          end
        end
        MULT: begin
          if (mplier_q[0]) begin
            prod_q <= prod_q + mcand_q;
          end
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          result_q <= aluRes_d;
          flags_q  <= aluFlags_d;
          done_q   <= 1'b1;
          wrEn_q   <= sBit_q & defined_d;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign status_out   = flags_q;
  assign status_wr_en = wrEn_q;

endmodule

// File: tb/tb_exec_flag_unit.sv
// Directed self-checking bench for exec_flag_unit: hand-computed vectors for
// the ALU ops, flag rules, multiplier latency, reset abort and ignored starts.
module tb_exec_flag_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  exe_cmd;
  logic        s_bit;
  logic [31:0] val1;
  logic [31:0] val2;
  logic [31:0] acc;
  logic [3:0]  status_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [3:0]  status_out;
  logic        status_wr_en;

  int checkCount = 0;
  int errorCount = 0;
  int lat;
  int busyCnt;
  int doneCnt;

  exec_flag_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .exe_cmd     (exe_cmd),
    .s_bit       (s_bit),
    .val1        (val1),
    .val2        (val2),
    .acc         (acc),
    .status_in   (status_in),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .status_out  (status_out),
    .status_wr_en(status_wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one operation for exactly one posedge; returns at the negedge
  // after acceptance, then scrambles status_in to prove it was latched.
  task automatic applyStimulus(input logic [3:0] cmd, input logic sb,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] ac, input logic [3:0] st);
    @(negedge clk);
    exe_cmd   = cmd;
    s_bit     = sb;
    val1      = a;
    val2      = b;
    acc       = ac;
    status_in = st;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    status_in = ~st;
  endtask

  // Bounded wait for done; lat counts posedges since acceptance.
  task automatic waitDone(output int latency, output int busyCycles);
    latency    = 0;
    busyCycles = 0;
    while (!done && latency < 80) begin
      if (busy) busyCycles++;
      @(negedge clk);
      latency++;
    end
    if (!done) checkOutput("doneTimeout", 64'd0, 64'd1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; exe_cmd = '0; s_bit = 1'b0;
    val1 = '0; val2 = '0; acc = '0; status_in = '0;

    // reset with a simultaneous start: start must be discarded
    @(negedge clk);
    rst = 1'b1; start = 1'b1; exe_cmd = 4'b0010;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checkOutput("rstBusy",   busy, 0);
    checkOutput("rstDone",   done, 0);
    checkOutput("rstResult", result, 0);
    checkOutput("rstStatus", status_out, 0);
    checkOutput("rstWrEn",   status_wr_en, 0);
    @(negedge clk);
    checkOutput("rstStartDiscard", {busy, done}, 2'b00);

    // ADD overflow into sign bit
    applyStimulus(4'b0010, 1'b1, 32'h7FFF_FFFF, 32'h1, 32'h0, 4'b0000);
    checkOutput("addBusy", busy, 1);
    waitDone(lat, busyCnt);
    checkOutput("addLat",    lat, 1);
    checkOutput("addResult", result, 32'h8000_0000);
    checkOutput("addStatus", status_out, 4'b1001);
    checkOutput("addWrEn",   status_wr_en, 1);
    @(negedge clk);
    checkOutput("addDonePulse", {done, status_wr_en}, 2'b00);
    checkOutput("addHoldRes",   result, 32'h8000_0000);
    checkOutput("addHoldStat",  status_out, 4'b1001);

    // SUB equal operands
    applyStimulus(4'b0100, 1'b1, 32'd5, 32'd5, 32'h0, 4'b1001);
    waitDone(lat, busyCnt);
    checkOutput("subResult", result, 32'h0);
    checkOutput("subStatus", status_out, 4'b0110);

    // SBC with C=0 borrows one more
    applyStimulus(4'b0101, 1'b1, 32'd5, 32'd5, 32'h0, 4'b0000);
    waitDone(lat, busyCnt);
    checkOutput("sbcResult", result, 32'hFFFF_FFFF);
    checkOutput("sbcStatus", status_out, 4'b1000);

    // ADC carry-in wraps to zero with carry out
    applyStimulus(4'b0011, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0, 4'b0010);
    waitDone(lat, busyCnt);
    checkOutput("adcResult", result, 32'h0);
    checkOutput("adcStatus", status_out, 4'b0110);

    // MVN passes C/V through
    applyStimulus(4'b1001, 1'b1, 32'h1234, 32'h0, 32'h0, 4'b0001);
    waitDone(lat, busyCnt);
    checkOutput("mvnResult", result, 32'hFFFF_FFFF);
    checkOutput("mvnStatus", status_out, 4'b1001);

    // AND with s_bit=0: flags computed but no write
    applyStimulus(4'b0110, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 4'b0010);
    waitDone(lat, busyCnt);
    checkOutput("andResult", result, 32'hF000_F000);
    checkOutput("andStatus", status_out, 4'b1010);
    checkOutput("andWrEn",   status_wr_en, 0);

    // MLA: 3*4 + 10 = 22
    applyStimulus(4'b1011, 1'b1, 32'd3, 32'd4, 32'd10, 4'b0011);
    waitDone(lat, busyCnt);
    checkOutput("mlaLat",    lat, 33);
    checkOutput("mlaBusy",   busyCnt, 33);
    checkOutput("mlaResult", result, 32'h16);
    checkOutput("mlaStatus", status_out, 4'b0011);
    checkOutput("mlaWrEn",   status_wr_en, 1);
    doneCnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    checkOutput("mlaDoneOnce", doneCnt, 0);

    // start while busy is ignored: MUL 6*7 = 42
    applyStimulus(4'b1010, 1'b1, 32'd6, 32'd7, 32'd0, 4'b0000);
    exe_cmd = 4'b0010; val1 = 32'd100; val2 = 32'd200; status_in = 4'b1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(lat, busyCnt);
    checkOutput("ignLat",    lat, 32);
    checkOutput("ignResult", result, 32'h2A);
    checkOutput("ignStatus", status_out, 4'b0000);
    doneCnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) doneCnt++;
    end
    checkOutput("ignNoSecondOp", doneCnt, 0);

    // undefined opcode
    applyStimulus(4'b1111, 1'b1, 32'd9, 32'd9, 32'd0, 4'b0101);
    waitDone(lat, busyCnt);
    checkOutput("undLat",    lat, 1);
    checkOutput("undResult", result, 32'h0);
    checkOutput("undStatus", status_out, 4'b0101);
    checkOutput("undWrEn",   status_wr_en, 0);

    // establish nonzero outputs, then abort a MUL with reset
    applyStimulus(4'b0010, 1'b1, 32'h7FFF_FFFF, 32'h1, 32'h0, 4'b0000);
    waitDone(lat, busyCnt);
    applyStimulus(4'b1010, 1'b1, 32'd3, 32'd5, 32'd0, 4'b0011);
    repeat (9) @(negedge clk);
    checkOutput("abortPreBusy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abortBusy",   busy, 0);
    checkOutput("abortDone",   done, 0);
    checkOutput("abortResult", result, 32'h0);
    checkOutput("abortStatus", status_out, 4'b0000);
    checkOutput("abortWrEn",   status_wr_en, 0);
    doneCnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) doneCnt++;
    end
    checkOutput("abortNoDone", doneCnt, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
